spi_slave_responder: RTL and testbench

SPI mode-0 slave (CPOL=0, CPHA=0) that sits at the far end of the link from our SPI master and its divided serial clock. The block oversamples the incoming SCLK, CS_N and MOSI pins in the system clock domain and detects SCLK edges. It shifts MOSI into parallel words and shifts parallel transmit words out on MISO. It gives the local control logic a per-word receive strobe and a transmit-load strobe.

---
 rtl/spi_slave_responder_pkg.sv | 14 +
 rtl/spi_slave_responder_if.sv | 20 ++
 rtl/spi_slave_responder_sync_edge_detect.sv | 32 +++
 rtl/spi_slave_responder.sv | 156 +++++++++++++++
 tb/tb_spi_slave_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_responder_pkg.sv
// Shared SPI definitions: state encoding, default word size and bus mode.
package spi_slave_responder_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    // {CPOL, CPHA}; mode 0 samples on SCLK rise and shifts on SCLK fall.
    localparam logic [1:0] SPI_MODE = 2'b00;

endpackage

// File: rtl/spi_slave_responder_if.sv
// SPI pin bundle shared by the master and the responder.
interface spi_slave_responder_if;

    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk, cs_n, mosi,
        input  miso, miso_oe
    );

    modport slave (
        input  sclk, cs_n, mosi,
        output miso, miso_oe
    );

endinterface

// File: rtl/spi_slave_responder_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall strobes.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus one extra copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled pins, MSB-first receive and transmit shifters.
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    spi_slave_responder_if.slave  spi,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_loaded_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_sync;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  word_done_q, word_done_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_loaded_q, tx_loaded_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] rx_word;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (spi.sclk),
        .level_o (sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (spi.cs_n),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // MOSI only needs its level, so it gets a bare synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mosi_sync_q <= '0;
        else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
    end
    assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_loaded_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            rx_valid_q  <= rx_valid_d;
            tx_loaded_q <= tx_loaded_d;
            miso_q      <= miso_d;
        end
    end

    // Next-state, shifting and strobe generation.
    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        rx_valid_d  = 1'b0;
        tx_loaded_d = 1'b0;
        miso_d      = 1'b0;
        rx_word     = {rx_shift_q, mosi_sync};

        case (state_q)
            IDLE: begin
                // Covers both a cs_fall and CS already low coming out of reset.
                if (!cs_level) begin
                    state_d     = ACTIVE;
                    tx_shift_d  = tx_data_i;
                    tx_loaded_d = 1'b1;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // Deselect discards any partial word and drops a coincident SCLK edge.
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = rx_word[DATA_WIDTH-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d   = rx_word;
                            rx_valid_d  = 1'b1;
                            bit_cnt_d   = '0;
                            word_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (word_done_q) begin
                            tx_shift_d  = tx_data_i;
                            tx_loaded_d = 1'b1;
                            word_done_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // MISO trails the shifter by one cycle in steady state; on entry it
        // follows the freshly loaded word so the first bit is ready at once.
        if (state_d == ACTIVE)
            miso_d = (state_q == ACTIVE) ? tx_shift_q[DATA_WIDTH-1] : tx_shift_d[DATA_WIDTH-1];
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = (state_q == ACTIVE);
    assign busy_o      = (state_q == ACTIVE);
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign tx_loaded_o = tx_loaded_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: table of single-word frames plus
// hand-written multi-word, abort, reset, idle-clock and latency sequences.
module tb_spi_slave_responder;

    localparam int HALF = 10;   // SCLK half period in CLK cycles (2.5 MHz vs 50 MHz)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data;
    logic       tx_loaded;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    spi_slave_responder_if spi_if ();

    spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .spi         (spi_if.slave),
        .tx_data_i   (tx_data),
        .tx_loaded_o (tx_loaded),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .busy_o      (busy)
    );

    always #10 clk = ~clk;

    // Pulse monitor: counts strobes, logs received words, flags strobes wider than one cycle.
    int         rv_cnt = 0;
    int         tl_cnt = 0;
    int         wide_cnt = 0;
    logic       rv_prev = 1'b0;
    logic       tl_prev = 1'b0;
    logic [7:0] rx_log[$];

    always @(posedge clk) begin
        if (rx_valid) begin
            rv_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_loaded) tl_cnt++;
        if (rx_valid && rv_prev) wide_cnt++;
        if (tx_loaded && tl_prev) wide_cnt++;
        rv_prev = rx_valid;
        tl_prev = tx_loaded;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One SCLK bit: MOSI set in the low phase, MISO sampled at the rise.
    task automatic spi_bit(input logic b, input logic upd, input logic [7:0] nt, input logic last,
                           output logic m, output int rx_lat, output int miso_lat);
        logic old;
        spi_if.mosi = b;
        repeat (HALF) @(negedge clk);
        spi_if.sclk = 1'b1;
        m = spi_if.miso;
        rx_lat = 0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (rx_valid && rx_lat == 0) rx_lat = i;
            if (upd && i == 5) tx_data = nt;
        end
        old = spi_if.miso;
        spi_if.sclk = 1'b0;
        if (last) spi_if.cs_n = 1'b1;
        miso_lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (spi_if.miso !== old && miso_lat == 0) miso_lat = i;
        end
    endtask

    task automatic xfer(input logic [7:0] mw, input logic upd, input logic [7:0] nt, input logic last,
                        output logic [7:0] got, output int rx_lat, output int miso_lat);
        logic m;
        int   rl, ml;
        got = '0;
        rx_lat = 0;
        miso_lat = 0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mw[i], upd && (i == 0), nt, last && (i == 0), m, rl, ml);
            got[i] = m;
            if (i == 0) rx_lat = rl;
            if (i == 7) miso_lat = ml;
        end
    endtask

    task automatic frame(input logic [7:0] mw, input logic [7:0] tx, output logic [7:0] got);
        int rl, ml;
        tx_data = tx;
        spi_if.cs_n = 1'b0;
        xfer(mw, 1'b0, tx, 1'b1, got, rl, ml);
        repeat (HALF) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] mosi_w;
        logic [7:0] tx_w;
        logic [7:0] exp_rx;
        logic [7:0] exp_master;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] got, g1, g2, g3;
        int rv0, tl0, q0, rl, ml;
        logic m;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E};

        spi_if.sclk = 1'b0;
        spi_if.cs_n = 1'b1;
        spi_if.mosi = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);

        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_tx_loaded", tx_loaded, 0);
        check("reset_busy", busy, 0);
        check("reset_miso", spi_if.miso, 0);
        check("reset_miso_oe", spi_if.miso_oe, 0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single-word frames from the table.
        for (int v = 0; v < 4; v++) begin
            rv0 = rv_cnt; tl0 = tl_cnt; q0 = rx_log.size();
            frame(vecs[v].mosi_w, vecs[v].tx_w, got);
            check("vec_rx_data", rx_data, vecs[v].exp_rx);
            check("vec_rx_valid_count", rv_cnt - rv0, 1);
            check("vec_tx_loaded_count", tl_cnt - tl0, 1);
            check("vec_master_rx", got, vecs[v].exp_master);
            check("vec_busy_after", busy, 0);
            if (rx_log.size() == q0 + 1) check("vec_logged_word", rx_log[q0], vecs[v].exp_rx);
            else check("vec_logged_count", rx_log.size() - q0, 1);
        end

        // Back-to-back words in one CS frame, TX_DATA updated after each RX_VALID.
        rv0 = rv_cnt; tl0 = tl_cnt; q0 = rx_log.size();
        tx_data = 8'h11;
        spi_if.cs_n = 1'b0;
        xfer(8'h01, 1'b1, 8'h22, 1'b0, g1, rl, ml);
        xfer(8'h80, 1'b1, 8'h33, 1'b0, g2, rl, ml);
        xfer(8'hFF, 1'b0, 8'h33, 1'b1, g3, rl, ml);
        repeat (HALF) @(negedge clk);
        check("b2b_rx_valid_count", rv_cnt - rv0, 3);
        check("b2b_tx_loaded_count", tl_cnt - tl0, 3);
        check("b2b_master_w0", g1, 8'h11);
        check("b2b_master_w1", g2, 8'h22);
        check("b2b_master_w2", g3, 8'h33);
        if (rx_log.size() == q0 + 3) begin
            check("b2b_rx_w0", rx_log[q0], 8'h01);
            check("b2b_rx_w1", rx_log[q0+1], 8'h80);
            check("b2b_rx_w2", rx_log[q0+2], 8'hFF);
        end else begin
            check("b2b_logged_count", rx_log.size() - q0, 3);
        end

        // Aborted word: 5 bits of 0xC3 then CS released.
        rv0 = rv_cnt;
        tx_data = 8'h99;
        spi_if.cs_n = 1'b0;
        spi_bit(1'b1, 1'b0, 8'h00, 1'b0, m, rl, ml);
        spi_bit(1'b1, 1'b0, 8'h00, 1'b0, m, rl, ml);
        spi_bit(1'b0, 1'b0, 8'h00, 1'b0, m, rl, ml);
        spi_bit(1'b0, 1'b0, 8'h00, 1'b0, m, rl, ml);
        spi_bit(1'b0, 1'b0, 8'h00, 1'b0, m, rl, ml);
        check("abort_busy_before", busy, 1);
        spi_if.cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_busy_3cyc", busy, 0);
        check("abort_miso_oe_3cyc", spi_if.miso_oe, 0);
        check("abort_miso", spi_if.miso, 0);
        repeat (HALF) @(negedge clk);
        check("abort_no_rx_valid", rv_cnt - rv0, 0);
        check("abort_rx_data_held", rx_data, 8'hFF);
        frame(8'h5A, 8'hC3, got);
        check("after_abort_rx", rx_data, 8'h5A);
        check("after_abort_master", got, 8'hC3);

        // Reset mid-word, with CS held low through reset.
        tx_data = 8'h77;
        spi_if.cs_n = 1'b0;
        spi_bit(1'b1, 1'b0, 8'h00, 1'b0, m, rl, ml);
        spi_bit(1'b1, 1'b0, 8'h00, 1'b0, m, rl, ml);
        spi_bit(1'b1, 1'b0, 8'h00, 1'b0, m, rl, ml);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_rx_data", rx_data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_miso_oe", spi_if.miso_oe, 0);
        check("rst_mid_miso", spi_if.miso, 0);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_tx_loaded", tx_loaded, 0);
        rv0 = rv_cnt; tl0 = tl_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_cs_low_busy", busy, 1);
        repeat (2) @(negedge clk);
        check("post_rst_tx_loaded", tl_cnt - tl0, 1);
        spi_if.cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        check("post_rst_no_rx_valid", rv_cnt - rv0, 0);
        check("post_rst_busy_off", busy, 0);

        // SCLK toggling with CS high must be ignored.
        rv0 = rv_cnt; tl0 = tl_cnt;
        for (int i = 0; i < 8; i++) begin
            spi_if.mosi = i[0];
            spi_if.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_if.sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        check("idle_clk_rx_valid", rv_cnt - rv0, 0);
        check("idle_clk_tx_loaded", tl_cnt - tl0, 0);
        check("idle_clk_miso", spi_if.miso, 0);
        check("idle_clk_miso_oe", spi_if.miso_oe, 0);

        // Latency: last-bit rise to RX_VALID, first fall to MISO change (0x55 -> 0 then 1).
        tx_data = 8'h55;
        spi_if.cs_n = 1'b0;
        xfer(8'h96, 1'b0, 8'h55, 1'b1, got, rl, ml);
        repeat (HALF) @(negedge clk);
        check("lat_rx_valid_cycles", rl, 3);
        check("lat_miso_cycles", ml, 4);
        check("lat_master_rx", got, 8'h55);
        check("lat_rx_data", rx_data, 8'h96);

        check("strobe_width_one_cycle", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not reach its end, got no finish expected finish");
        $fatal(1);
    end

endmodule
